// File: rtl/glyph_blitter_if.sv
// Command handshake and framebuffer write bundle for glyph_blitter.
// The master side issues commands and consumes pixel writes; the slave side is the blitter.
interface glyph_blitter_if #(
   parameter int COLOR_W = 8
);
   logic               cmd_valid;
   logic               cmd_ready;
   logic [7:0]         cmd_char;
   logic [6:0]         cmd_col;
   logic [6:0]         cmd_row;
   logic [COLOR_W-1:0] cmd_fg;
   logic [COLOR_W-1:0] cmd_bg;
   logic               cmd_err;
   logic               fb_wr;
   logic [31:0]        fb_addr;
   logic [COLOR_W-1:0] fb_data;
   logic               busy;

   modport master (
      output cmd_valid, cmd_char, cmd_col, cmd_row, cmd_fg, cmd_bg,
      input  cmd_ready, cmd_err, fb_wr, fb_addr, fb_data, busy
   );

   modport slave (
      input  cmd_valid, cmd_char, cmd_col, cmd_row, cmd_fg, cmd_bg,
      output cmd_ready, cmd_err, fb_wr, fb_addr, fb_data, busy
   );
endinterface

// File: rtl/glyph_blitter.sv
// Command-driven character renderer: font RAM lookup, power-of-two scaling, one pixel write per cycle.
// Define GLYPH_BLITTER_TRANSPARENT_EN to suppress writes of background (glyph bit 0) pixels.
module glyph_blitter #(
   parameter int PIXEL_WIDTH     = 640,
   parameter int PIXEL_HEIGHT    = 480,
   parameter int SCALE           = 2,
   parameter int FONT_NUM_CHARS  = 96,
   parameter int FONT_FIRST_CHAR = 32,
   parameter int COLOR_W         = 8
) (
   input  logic           pclk,
   input  logic           rst_n,
   input  logic           ioctl_wr,
   input  logic [26:0]    ioctl_addr,
   input  logic [7:0]     ioctl_dout,
   glyph_blitter_if.slave bus
);
   localparam int CHAR_W     = 32'd8 << (SCALE - 1);
   localparam int CHAR_H     = CHAR_W;
   localparam int COLS       = PIXEL_WIDTH / CHAR_W;
   localparam int ROWS       = PIXEL_HEIGHT / CHAR_H;
   localparam int SHIFT      = SCALE - 1;
   localparam int FONT_BYTES = FONT_NUM_CHARS * 32'd8;
   localparam int IDX_W      = (FONT_NUM_CHARS > 1) ? $clog2(FONT_NUM_CHARS) : 1;
   localparam int FA_W       = IDX_W + 3;
   localparam int CNT_W      = $clog2(CHAR_W);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAR_W - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(32'd1);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DRAW  = 2'd2
   } state_t;

   state_t             state, state_next;
   logic [7:0]         font_ram [FONT_BYTES];
   logic [FA_W-1:0]    font_rd_addr;
   logic [7:0]         font_byte;
   logic [CNT_W-1:0]   pixel_row, pixel_row_next;
   logic [CNT_W-1:0]   pixel_col, pixel_col_next;
   logic [7:0]         row_bits, row_bits_next;
   logic [IDX_W-1:0]   glyph_idx, glyph_idx_next;
   logic [31:0]        base, base_next;
   logic [COLOR_W-1:0] fg, fg_next, bg, bg_next;
   logic               ready, ready_next;
   logic               err, err_next;
   logic               wr, wr_next;
   logic [31:0]        addr, addr_next;
   logic [COLOR_W-1:0] data, data_next;
   logic               busy_flag;
   logic [CNT_W-1:0]   pix_col;
   logic [7:0]         pix_byte;
   logic               pix_bit;
   logic               pix_wr;
   logic [31:0]        pix_addr;
   logic [COLOR_W-1:0] pix_data;
   logic               off_screen;
   logic               in_font;
   logic               unused_bits;

`ifdef GLYPH_BLITTER_TRANSPARENT_EN
   assign unused_bits = ^{ioctl_addr[26:10], bg};
`else
   assign unused_bits = ^ioctl_addr[26:10];
`endif

   // Font download; no reset so glyphs survive rst_n.
   always_ff @(posedge pclk) begin
      if (ioctl_wr && ({22'd0, ioctl_addr[9:0]} < 32'(FONT_BYTES))) begin
         font_ram[FA_W'(ioctl_addr[9:0])] <= ioctl_dout;
      end
   end

   // Pixel shown next cycle: column 0 straight from the font byte in FETCH, else the next column of the latched row.
   always_comb begin
      font_rd_addr = {glyph_idx, 3'(pixel_row >> SHIFT)};
      font_byte    = font_ram[font_rd_addr];
      if (state == FETCH) begin
         pix_col  = CNT_ZERO;
         pix_byte = font_byte;
      end else begin
         pix_col  = pixel_col + CNT_ONE;
         pix_byte = row_bits;
      end
      pix_bit  = pix_byte[3'd7 - 3'(pix_col >> SHIFT)];
      pix_addr = base + 32'(pixel_row) * 32'(PIXEL_WIDTH) + 32'(pix_col);
`ifdef GLYPH_BLITTER_TRANSPARENT_EN
      pix_wr   = pix_bit;
      pix_data = fg;
`else
      pix_wr   = 1'b1;
      pix_data = pix_bit ? fg : bg;
`endif
   end

   // Next-state decode; registered outputs are computed here one cycle ahead.
   always_comb begin
      state_next     = state;
      pixel_row_next = pixel_row;
      pixel_col_next = pixel_col;
      row_bits_next  = row_bits;
      glyph_idx_next = glyph_idx;
      base_next      = base;
      fg_next        = fg;
      bg_next        = bg;
      ready_next     = 1'b0;
      err_next       = 1'b0;
      wr_next        = 1'b0;
      addr_next      = addr;
      data_next      = data;
      off_screen     = (32'(bus.cmd_col) >= 32'(COLS)) || (32'(bus.cmd_row) >= 32'(ROWS));
      in_font        = (32'(bus.cmd_char) >= 32'(FONT_FIRST_CHAR)) &&
                       (32'(bus.cmd_char) < 32'(FONT_FIRST_CHAR + FONT_NUM_CHARS));
      case (state)
         IDLE: begin
            ready_next = 1'b1;
            if (bus.cmd_valid && off_screen) begin
               err_next = 1'b1;
            end else if (bus.cmd_valid) begin
               state_next     = FETCH;
               ready_next     = 1'b0;
               pixel_row_next = CNT_ZERO;
               pixel_col_next = CNT_ZERO;
               fg_next        = bus.cmd_fg;
               bg_next        = bus.cmd_bg;
               base_next      = 32'(bus.cmd_row) * 32'(CHAR_H * PIXEL_WIDTH) +
                                32'(bus.cmd_col) * 32'(CHAR_W);
               if (in_font) begin
                  glyph_idx_next = IDX_W'(32'(bus.cmd_char) - 32'(FONT_FIRST_CHAR));
               end else begin
                  glyph_idx_next = {IDX_W{1'b0}};
               end
            end else begin
               state_next = IDLE;
            end
         end
         FETCH: begin
            state_next     = DRAW;
            row_bits_next  = font_byte;
            pixel_col_next = CNT_ZERO;
            wr_next        = pix_wr;
            addr_next      = pix_addr;
            data_next      = pix_data;
         end
         DRAW: begin
            if (pixel_col != CNT_LAST) begin
               pixel_col_next = pix_col;
               wr_next        = pix_wr;
               addr_next      = pix_addr;
               data_next      = pix_data;
            end else if (pixel_row != CNT_LAST) begin
               state_next     = FETCH;
               pixel_row_next = pixel_row + CNT_ONE;
               pixel_col_next = CNT_ZERO;
            end else begin
               state_next     = IDLE;
               ready_next     = 1'b1;
               pixel_row_next = CNT_ZERO;
               pixel_col_next = CNT_ZERO;
            end
         end
         default: begin
            state_next = IDLE;
            ready_next = 1'b1;
         end
      endcase
   end

   // State, counters, latched command and registered outputs.
   always_ff @(posedge pclk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         pixel_row <= CNT_ZERO;
         pixel_col <= CNT_ZERO;
         row_bits  <= 8'd0;
         glyph_idx <= {IDX_W{1'b0}};
         base      <= 32'd0;
         fg        <= {COLOR_W{1'b0}};
         bg        <= {COLOR_W{1'b0}};
         ready     <= 1'b1;
         err       <= 1'b0;
         wr        <= 1'b0;
         addr      <= 32'd0;
         data      <= {COLOR_W{1'b0}};
         busy_flag <= 1'b0;
      end else begin
         state     <= state_next;
         pixel_row <= pixel_row_next;
         pixel_col <= pixel_col_next;
         row_bits  <= row_bits_next;
         glyph_idx <= glyph_idx_next;
         base      <= base_next;
         fg        <= fg_next;
         bg        <= bg_next;
         ready     <= ready_next;
         err       <= err_next;
         wr        <= wr_next;
         addr      <= addr_next;
         data      <= data_next;
         busy_flag <= ~ready_next;
      end
   end

   assign bus.cmd_ready = ready;
   assign bus.cmd_err   = err;
   assign bus.fb_wr     = wr;
   assign bus.fb_addr   = addr;
   assign bus.fb_data   = data;
   assign bus.busy      = busy_flag;
endmodule

// File: doc/glyph_blitter.md
# glyph_blitter

Parametrised successor to the boot-time font dump: a command-driven character renderer for the pixel-clock framebuffer path. Accepts one character command at a time (code, column, row, foreground/background colour) over a valid/ready handshake. Looks the glyph up in an internal font RAM loaded over the ioctl download port. Emits one framebuffer pixel write per cycle to the `vga` CPU write port, with integer power-of-two scaling.

## Interface
- PIXEL_WIDTH, 640, framebuffer width in pixels
- PIXEL_HEIGHT, 480, framebuffer height in pixels
- SCALE, 2, glyph magnification exponent+1; legal 1 (8x8), 2 (16x16), 3 (32x32)
- FONT_NUM_CHARS, 96, glyphs in font RAM (8 bytes each, byte = one row, MSB leftmost)
- FONT_FIRST_CHAR, 32, character code of glyph index 0
- COLOR_W, 8, pixel data width
- pclk  in  1  pixel clock; sole clock
- rst_n  in  1  reset, asynchronous assert, active-low
- ioctl_wr  in  1  font byte write strobe
- ioctl_addr  in  27  font byte address; bits [9:0] used
- ioctl_dout  in  8  font byte
- cmd_valid  in  1  command present
- cmd_ready  out  1  block idle, command accepted when both high
- cmd_char  in  8  character code
- cmd_col  in  7  character column
- cmd_row  in  7  character row
- cmd_fg  in  COLOR_W  colour for glyph bit 1
- cmd_bg  in  COLOR_W  colour for glyph bit 0
- cmd_err  out  1  one-cycle pulse: command dropped (position off-screen)
- fb_wr  out  1  framebuffer write strobe
- fb_addr  out  32  framebuffer pixel address
- fb_data  out  COLOR_W  framebuffer pixel data
- busy  out  1  high while not IDLE

## Operation
- Derived: CHAR_W = CHAR_H = 8<<(SCALE-1); COLS = PIXEL_WIDTH/CHAR_W; ROWS = PIXEL_HEIGHT/CHAR_H.
- Font RAM: FONT_NUM_CHARS*8 bytes. Written whenever ioctl_wr is high, including mid-render; reads see the new byte on the following cycle. Addresses at or above the RAM size are ignored. Contents are not reset.
- FSM: IDLE -> FETCH -> DRAW -> (FETCH | IDLE).
- IDLE: cmd_ready=1. On accept:
  - cmd_col>=COLS or cmd_row>=ROWS: pulse cmd_err next cycle, stay IDLE, no writes.
  - Otherwise latch fg/bg and glyph index = cmd_char-FONT_FIRST_CHAR. Codes outside [FIRST, FIRST+NUM) map to index 0.
  - base = cmd_row*CHAR_H*PIXEL_WIDTH + cmd_col*CHAR_W, computed 32-bit. Go to FETCH.
- FETCH (1 cycle): read font byte index*8 + (pixel_row>>(SCALE-1)) into the row shift register; fb_wr=0.
- DRAW (CHAR_W cycles): fb_wr=1; fb_addr = base + pixel_row*PIXEL_WIDTH + pixel_col; fb_data = bit (7 - (pixel_col>>(SCALE-1))) ? fg : bg.
  - After pixel_col = CHAR_W-1: if pixel_row = CHAR_H-1, go to IDLE; else increment pixel_row and go to FETCH.
- Raster order within a glyph; each font row is replicated 2^(SCALE-1) times vertically and each bit 2^(SCALE-1) times horizontally.
- Reset (any time, including mid-glyph): FSM to IDLE and all counters cleared. Outputs: cmd_ready=1, cmd_err=0, fb_wr=0, fb_addr=0, fb_data=0, busy=0. A command in flight is lost.

## Timing
- All outputs registered.
- Accept at cycle T. First FETCH at T+1; first fb_wr at T+2.
- Each glyph row: one FETCH gap cycle, then CHAR_W consecutive write cycles.
- Last write at T+CHAR_H*(CHAR_W+1); cmd_ready=1 the cycle after. SCALE=2: last write T+272, ready T+273.
- Dropped command: cmd_err at T+1; cmd_ready remains 1 throughout.
- busy = !cmd_ready.

## Configuration
- GLYPH_BLITTER_TRANSPARENT_EN defined: glyph-0 pixels drive fb_wr=0 (address still advances, cycle count unchanged). cmd_bg is ignored and only foreground pixels are written.
- Undefined: every glyph pixel is written; background uses cmd_bg.

## Test plan
- Load byte 0x81 at font addr 264 (code 0x41 row 0), rest of glyph 0x00. Command 'A' col0 row0, fg=0xFF, bg=0x00, SCALE=2 -> addr 0..15 data FF,FF,00x12,FF,FF; addr 640..655 identical; addr 1280..1295 all 00; 256 writes total.
- Command col=39 row=29, SCALE=2 -> first fb_addr 297584, last fb_addr 307199, cmd_ready high the cycle after the last write.
- Command col=40 row=0 -> cmd_err single pulse at T+1, zero fb_wr, cmd_ready never low.
- Command cmd_char=0x10 -> renders glyph index 0 (font addr 0..7).
- cmd_valid held high with two commands -> second accepted at T+273; exactly 512 writes; FETCH gap cycles with fb_wr=0 observed between rows.
- Deassert rst_n at the 100th write -> fb_wr=0 in the same cycle; after release cmd_ready=1; font RAM readback unchanged. With GLYPH_BLITTER_TRANSPARENT_EN, rerun scenario 1 -> only 8 writes per pixel row pair (addrs 0,1,14,15 and 640,641,654,655).
